muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl.sv | 137 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Multiply/divide controller for the Execute stage.
// Multiplies take one stall cycle. Divides are restoring radix-2 and take 33 stall cycles. Results go to HI/LO.
module muldiv_ctrl #(
    // Op codes mirrored from defines2.vh; override if that file changes.
    parameter logic [4:0] MULT_CONTROL  = 5'b11000,
    parameter logic [4:0] MULTU_CONTROL = 5'b11001,
    parameter logic [4:0] DIV_CONTROL   = 5'b11010,
    parameter logic [4:0] DIVU_CONTROL  = 5'b11011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  alu_controlE,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        stallE,
    input  logic        flushE,
    output logic        stall_div,
    output logic [63:0] hilo_out,
    output logic        hilo_valid
);

    typedef enum logic [1:0] {IDLE, DIV_ON, DONE} state_t;

    state_t      state;
    logic [4:0]  count;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] div_mag;
    logic        q_neg;
    logic        r_neg;
    logic [63:0] hilo_prev;

    logic        is_mult, is_multu, is_div, is_divu, start;
    logic [31:0] a_mag, b_mag;
    logic [63:0] mul_s, mul_u;
    logic [32:0] rem_sh, diff;
    logic        fits;
    logic [31:0] rem_nx, quo_nx, rem_fix, quo_fix;

    assign is_mult  = (alu_controlE == MULT_CONTROL);
    assign is_multu = (alu_controlE == MULTU_CONTROL);
    assign is_div   = (alu_controlE == DIV_CONTROL);
    assign is_divu  = (alu_controlE == DIVU_CONTROL);

    assign start = !rst && !flushE && (state == IDLE) &&
                   (is_mult || is_multu || is_div || is_divu);

    // The stall must rise in the start cycle itself, so it is not registered.
    assign stall_div = !rst && !flushE && (start || state == DIV_ON);

    assign a_mag = (is_div && a[31]) ? -a : a;
    assign b_mag = (is_div && b[31]) ? -b : b;

    // The low 64 bits of a 64x64 product of the extended operands are the exact 32x32 result.
    assign mul_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign mul_u = {32'd0, a} * {32'd0, b};

    // One restoring step: shift in the next dividend bit and try subtracting the divisor.
    assign rem_sh  = {rem, quo[31]};
    assign diff    = rem_sh - {1'b0, div_mag};
    assign fits    = !diff[32];
    assign rem_nx  = fits ? diff[31:0] : rem_sh[31:0];
    assign quo_nx  = {quo[30:0], fits};
    assign quo_fix = q_neg ? -quo_nx : quo_nx;
    assign rem_fix = r_neg ? -rem_nx : rem_nx;

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= 5'd0;
            quo        <= 32'd0;
            rem        <= 32'd0;
            div_mag    <= 32'd0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            hilo_prev  <= 64'd0;
            hilo_out   <= 64'd0;
            hilo_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        hilo_prev <= hilo_out;
                        if (is_mult || is_multu) begin
                            hilo_out   <= is_mult ? mul_s : mul_u;
                            hilo_valid <= 1'b1;
                            state      <= DONE;
                        end else if (b == 32'd0) begin
                            hilo_out   <= 64'd0;
                            hilo_valid <= 1'b1;
                            state      <= DONE;
                        end else begin
                            quo     <= a_mag;
                            rem     <= 32'd0;
                            div_mag <= b_mag;
                            q_neg   <= is_div && (a[31] ^ b[31]);
                            r_neg   <= is_div && a[31];
                            count   <= 5'd0;
                            state   <= DIV_ON;
                        end
                    end
                end
                DIV_ON: begin
                    if (flushE) begin
                        state <= IDLE;
                    end else begin
                        quo   <= quo_nx;
                        rem   <= rem_nx;
                        count <= count + 5'd1;
                        if (count == 5'd31) begin
                            hilo_out   <= {rem_fix, quo_fix};
                            hilo_valid <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    // A flushed op must leave HI/LO as it was before the op started.
                    if (flushE) begin
                        hilo_out   <= hilo_prev;
                        hilo_valid <= 1'b0;
                        state      <= IDLE;
                    end else if (!stallE) begin
                        hilo_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    hilo_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed testbench for muldiv_ctrl.
// Expected results are hand-computed; each comparison is checked with an immediate assertion.
module tb_muldiv_ctrl;

    localparam logic [4:0] NOP   = 5'b00000;
    localparam logic [4:0] MULT  = 5'b11000;
    localparam logic [4:0] MULTU = 5'b11001;
    localparam logic [4:0] DIV   = 5'b11010;
    localparam logic [4:0] DIVU  = 5'b11011;

    logic        clk;
    logic        rst;
    logic [4:0]  alu_controlE;
    logic [31:0] a;
    logic [31:0] b;
    logic        stallE;
    logic        flushE;
    logic        stall_div;
    logic [63:0] hilo_out;
    logic        hilo_valid;

    int tests  = 0;
    int failed = 0;
    int cycles;

    muldiv_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .alu_controlE (alu_controlE),
        .a            (a),
        .b            (b),
        .stallE       (stallE),
        .flushE       (flushE),
        .stall_div    (stall_div),
        .hilo_out     (hilo_out),
        .hilo_valid   (hilo_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge. Counts the cycles with stall_div high, then scrambles the operands to show they are latched.
    task automatic start_and_wait(input logic [4:0] op, input logic [31:0] av, input logic [31:0] bv,
                                  output int n);
        alu_controlE = op;
        a = av;
        b = bv;
        #1;
        n = 0;
        while (stall_div === 1'b1 && n < 200) begin
            n++;
            @(posedge clk);
            #1;
            a = 32'hDEADBEEF;
            b = 32'd0;
        end
    endtask

    // Called in the DONE cycle with stallE low. The instruction then advances.
    task automatic finish_op(input string tag, input logic [63:0] exp);
        chk({tag, " valid"}, {63'd0, hilo_valid}, 64'd1);
        chk({tag, " hilo"}, hilo_out, exp);
        chk({tag, " stall in done"}, {63'd0, stall_div}, 64'd0);
        alu_controlE = NOP;
        @(posedge clk);
        #1;
        chk({tag, " valid drops"}, {63'd0, hilo_valid}, 64'd0);
        chk({tag, " hilo held"}, hilo_out, exp);
    endtask

    initial begin
        rst = 1'b1;
        alu_controlE = NOP;
        a = 32'd0;
        b = 32'd0;
        stallE = 1'b0;
        flushE = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset hilo", hilo_out, 64'd0);
        chk("reset valid", {63'd0, hilo_valid}, 64'd0);
        chk("reset stall", {63'd0, stall_div}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Unsigned divide: 100 / 7 = 14 remainder 2.
        start_and_wait(DIVU, 32'd100, 32'd7, cycles);
        chk("divu cycles", 64'(cycles), 64'd33);
        finish_op("divu 100/7", 64'h00000002_0000000E);

        // Signed divide: -7 / 2 = -3 remainder -1.
        start_and_wait(DIV, 32'hFFFFFFF9, 32'd2, cycles);
        chk("div cycles", 64'(cycles), 64'd33);
        finish_op("div -7/2", 64'hFFFFFFFF_FFFFFFFD);

        // Overflow case: the most negative value divided by -1.
        start_and_wait(DIV, 32'h80000000, 32'hFFFFFFFF, cycles);
        chk("div ovf cycles", 64'(cycles), 64'd33);
        finish_op("div min/-1", 64'h00000000_80000000);

        start_and_wait(MULT, 32'hFFFFFFFF, 32'd2, cycles);
        chk("mult cycles", 64'(cycles), 64'd1);
        finish_op("mult -1*2", 64'hFFFFFFFF_FFFFFFFE);

        start_and_wait(MULTU, 32'hFFFFFFFF, 32'd2, cycles);
        chk("multu cycles", 64'(cycles), 64'd1);
        finish_op("multu", 64'h00000001_FFFFFFFE);

        // A flush in IDLE blocks the start.
        alu_controlE = DIVU;
        a = 32'd5;
        b = 32'd1;
        flushE = 1'b1;
        #1;
        chk("idle flush stall", {63'd0, stall_div}, 64'd0);
        @(posedge clk);
        #1;
        flushE = 1'b0;
        alu_controlE = NOP;
        #1;
        chk("idle flush no start", {63'd0, stall_div}, 64'd0);
        chk("idle flush valid", {63'd0, hilo_valid}, 64'd0);
        chk("idle flush hilo", hilo_out, 64'h00000001_FFFFFFFE);
        @(posedge clk);
        #1;

        // Flush during iteration 10 of a divide.
        alu_controlE = DIV;
        a = 32'd1000;
        b = 32'd3;
        #1;
        chk("flush div start stall", {63'd0, stall_div}, 64'd1);
        repeat (11) @(posedge clk);
        #1;
        chk("iter10 stall", {63'd0, stall_div}, 64'd1);
        flushE = 1'b1;
        alu_controlE = NOP;
        #1;
        chk("stall during flush", {63'd0, stall_div}, 64'd0);
        @(posedge clk);
        #1;
        flushE = 1'b0;
        chk("post flush stall", {63'd0, stall_div}, 64'd0);
        chk("post flush valid", {63'd0, hilo_valid}, 64'd0);
        chk("post flush hilo", hilo_out, 64'h00000001_FFFFFFFE);
        @(posedge clk);
        #1;
        chk("post flush no late valid", {63'd0, hilo_valid}, 64'd0);

        // Flush in DONE restores the pre-operation HI/LO value.
        start_and_wait(MULT, 32'd3, 32'd5, cycles);
        chk("mult flush cycles", 64'(cycles), 64'd1);
        chk("mult flush done hilo", hilo_out, 64'd15);
        chk("mult flush done valid", {63'd0, hilo_valid}, 64'd1);
        flushE = 1'b1;
        alu_controlE = NOP;
        #1;
        chk("done flush stall", {63'd0, stall_div}, 64'd0);
        @(posedge clk);
        #1;
        flushE = 1'b0;
        chk("done flush valid", {63'd0, hilo_valid}, 64'd0);
        chk("done flush hilo restored", hilo_out, 64'h00000001_FFFFFFFE);

        start_and_wait(DIVU, 32'd123, 32'd0, cycles);
        chk("divu by 0 cycles", 64'(cycles), 64'd1);
        finish_op("divu by 0", 64'd0);

        // Divide whose DONE state is held by stallE for 3 cycles.
        start_and_wait(DIVU, 32'd100, 32'd7, cycles);
        chk("held divu cycles", 64'(cycles), 64'd33);
        stallE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                stallE = 1'b0;
                alu_controlE = NOP;
            end
            #1;
            chk($sformatf("held valid %0d", i), {63'd0, hilo_valid}, 64'd1);
            chk($sformatf("held no restart %0d", i), {63'd0, stall_div}, 64'd0);
            chk($sformatf("held hilo %0d", i), hilo_out, 64'h00000002_0000000E);
            @(posedge clk);
            #1;
        end
        chk("held exit valid", {63'd0, hilo_valid}, 64'd0);
        chk("held exit stall", {63'd0, stall_div}, 64'd0);

        // Back-to-back: an op left on the bus restarts only from IDLE.
        start_and_wait(MULTU, 32'd3, 32'd5, cycles);
        chk("b2b first valid", {63'd0, hilo_valid}, 64'd1);
        chk("b2b first hilo", hilo_out, 64'd15);
        @(posedge clk);
        #1;
        a = 32'd6;
        b = 32'd7;
        #1;
        chk("b2b idle valid", {63'd0, hilo_valid}, 64'd0);
        chk("b2b restart stall", {63'd0, stall_div}, 64'd1);
        @(posedge clk);
        #1;
        alu_controlE = NOP;
        chk("b2b second valid", {63'd0, hilo_valid}, 64'd1);
        chk("b2b second hilo", hilo_out, 64'd42);
        @(posedge clk);
        #1;
        chk("b2b second exit", {63'd0, hilo_valid}, 64'd0);

        // Reset during iteration 10 of a divide.
        alu_controlE = DIV;
        a = 32'd1000;
        b = 32'd3;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        alu_controlE = NOP;
        #1;
        chk("rst mid div stall", {63'd0, stall_div}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst mid div hilo", hilo_out, 64'd0);
        chk("rst mid div valid", {63'd0, hilo_valid}, 64'd0);
        chk("rst mid div stall after", {63'd0, stall_div}, 64'd0);
        repeat (34) begin
            @(posedge clk);
            #1;
            chk("rst no valid pulse", {63'd0, hilo_valid}, 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
